// File: rtl/clk_div_ratio_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_ratio_ctrl_pkg
// Shared types and helpers for the divide-ratio sequencing controller.
//   state_t      : controller FSM states (IDLE / DRAIN / SETTLE)
//   DEF_RATIO_W  : default width of a divide ratio
//   CNT_W        : drain/settle counter width (one bit wider than a ratio)
//   seq_len()    : drain/settle length for a ratio, 2*ratio with a floor of 2
// -----------------------------------------------------------------------------
package clk_div_ratio_ctrl_pkg;

  localparam int DEF_RATIO_W = 5;
  localparam int CNT_W       = DEF_RATIO_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Two divided-clock periods of the given ratio. Ratios 0 and 1 bypass the
  // divider, so two reference cycles are still allowed for the output to
  // become quiet.
  function automatic int seq_len(input int ratio);
    return (ratio < 2) ? 2 : 2 * ratio;
  endfunction

endpackage

// File: rtl/clk_div_ratio_rr_arb.sv
// -----------------------------------------------------------------------------
// clk_div_ratio_rr_arb
// Two-way round-robin arbiter for ratio change requests.
// Ports:
//   clk    in   reference clock
//   rst_n  in   asynchronous active-low reset
//   en     in   arbitration allowed this cycle
//   valid  in   [1:0] request valids
//   grant  out  [1:0] one-hot grant (combinational)
// When both requesters are valid the pointer decides; after any grant the
// pointer moves to the requester that was not served.
// -----------------------------------------------------------------------------
module clk_div_ratio_rr_arb
  import clk_div_ratio_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (grant != 2'b00) begin
      // grant[0] set means requester 0 was served, so requester 1 is next.
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/clk_div_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ratio_ctrl
// Sequences divide-ratio changes for the configurable clock divider: grants
// one of two requesters, gates the divider enable while the old divided clock
// drains, applies the new ratio, then holds off until the new clock settles.
// Ports:
//   i_ref_clk                  reference clock (rising edge)
//   i_rst_n                    asynchronous active-low reset
//   i_req0_valid/_ratio        requester 0 change request
//   o_req0_ready               requester 0 handshake (Mealy, IDLE only)
//   i_req1_valid/_ratio        requester 1 change request
//   o_req1_ready               requester 1 handshake
//   o_div_ratio                ratio driven to the divider
//   o_clk_en                   divider enable
//   o_busy                     change sequence in progress
//   o_done                     one-cycle pulse: sequence finished / no-op
//   o_err                      one-cycle pulse: request rejected
// Build option: CLK_DIV_RATIO_CTRL_RANGE_CHECK_EN rejects ratios 0 and 1
// (o_err pulses); without it o_err stays 0 and every ratio is sequenced.
// -----------------------------------------------------------------------------
module clk_div_ratio_ctrl
  import clk_div_ratio_ctrl_pkg::*;
#(
  parameter int                 RATIO_W     = DEF_RATIO_W,
  parameter logic [RATIO_W-1:0] RESET_RATIO = RATIO_W'(8)
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_req0_valid,
  input  logic [RATIO_W-1:0] i_req0_ratio,
  output logic               o_req0_ready,
  input  logic               i_req1_valid,
  input  logic [RATIO_W-1:0] i_req1_ratio,
  output logic               o_req1_ready,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_clk_en,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int CW = RATIO_W + 1;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [RATIO_W-1:0] new_ratio, new_ratio_n;
  logic [RATIO_W-1:0] div_ratio_n;
  logic               clk_en_n, busy_n, done_n, err_n;
  logic [1:0]         grant;
  logic [RATIO_W-1:0] gnt_ratio;
  logic               reject;
  logic               arb_en;

  // The done cycle is kept out of arbitration so the next grant lands in the
  // cycle after o_done.
  assign arb_en = (state == ST_IDLE) && !o_done;

  clk_div_ratio_rr_arb u_arb (
    .clk   (i_ref_clk),
    .rst_n (i_rst_n),
    .en    (arb_en),
    .valid ({i_req1_valid, i_req0_valid}),
    .grant (grant)
  );

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];
  assign gnt_ratio    = grant[1] ? i_req1_ratio : i_req0_ratio;

`ifdef CLK_DIV_RATIO_CTRL_RANGE_CHECK_EN
  assign reject = (gnt_ratio < RATIO_W'(2));
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    new_ratio_n = new_ratio;
    div_ratio_n = o_div_ratio;
    clk_en_n    = o_clk_en;
    busy_n      = o_busy;
    done_n      = 1'b0;
    err_n       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          new_ratio_n = gnt_ratio;
          if (reject) begin
            err_n = 1'b1;
          end else if (gnt_ratio == o_div_ratio) begin
            done_n = 1'b1;
          end else begin
            clk_en_n = 1'b0;
            busy_n   = 1'b1;
            cnt_n    = CW'(seq_len(int'(o_div_ratio)));
            state_n  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Count 1 at an edge marks the last drain cycle: swap the ratio and
        // re-enable on the same edge so the ratio never moves while enabled.
        if (cnt <= CW'(1)) begin
          div_ratio_n = new_ratio;
          clk_en_n    = 1'b1;
          cnt_n       = CW'(seq_len(int'(new_ratio)));
          state_n     = ST_SETTLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt <= CW'(1)) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      new_ratio   <= RESET_RATIO;
      o_div_ratio <= RESET_RATIO;
      o_clk_en    <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      new_ratio   <= new_ratio_n;
      o_div_ratio <= div_ratio_n;
      o_clk_en    <= clk_en_n;
      o_busy      <= busy_n;
      o_done      <= done_n;
      o_err       <= err_n;
    end
  end

endmodule
